// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: field widths,
// forwarding-select encoding and the memory-wait FSM states.
package pipe_pkg;

  localparam int REG_W   = 5;
  localparam int LOAD_W  = 3;
  localparam int STORE_W = 2;
  localparam int BR_W    = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } hz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one execute-stage ALU operand. A load result in
// EX/MEM is not available yet, so it never forwards from there; x0 never
// forwards.
module fwd_unit
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0]  rs_e,
  input  logic [REG_W-1:0]  rd_m,
  input  logic              wreg_m,
  input  logic [LOAD_W-1:0] load_m,
  input  logic [REG_W-1:0]  rd_w,
  input  logic              wreg_w,
  output logic [1:0]        fwd_sel
);

  // EX/MEM result wins over writeback data when both match
  always_comb begin
    fwd_sel = FWD_RF;
    if (wreg_m && (rd_m != '0) && (load_m == '0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (wreg_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, with the
// data-memory wait FSM, timeout error and stall/flush event counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_W-1:0]   rs1_d,
  input  logic [REG_W-1:0]   rs2_d,
  input  logic               use_r2_d,
  input  logic [REG_W-1:0]   rs1_e,
  input  logic [REG_W-1:0]   rs2_e,
  input  logic [REG_W-1:0]   rd_e,
  input  logic               wreg_e,
  input  logic [LOAD_W-1:0]  load_e,
  input  logic [REG_W-1:0]   rd_m,
  input  logic               wreg_m,
  input  logic [LOAD_W-1:0]  load_m,
  input  logic [STORE_W-1:0] store_m,
  input  logic               br_taken_m,
  input  logic [REG_W-1:0]   rd_w,
  input  logic               wreg_w,
  input  logic               dmem_ready,
  output logic               stall_f,
  output logic               stall_d,
  output logic               stall_e,
  output logic               stall_m,
  output logic               flush_fd,
  output logic               flush_de,
  output logic               flush_em,
  output logic               flush_mw,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               mem_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  hz_state_e        state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       mem_wait, load_use;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign mem_wait = ((load_m != '0) || (store_m != '0)) && !dmem_ready;
  assign load_use = wreg_e && (load_e != '0) && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (use_r2_d && (rd_e == rs2_d)));

  fwd_unit u_fwd_a (
    .rs_e    (rs1_e),
    .rd_m    (rd_m),
    .wreg_m  (wreg_m),
    .load_m  (load_m),
    .rd_w    (rd_w),
    .wreg_w  (wreg_w),
    .fwd_sel (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .rs_e    (rs2_e),
    .rd_m    (rd_m),
    .wreg_m  (wreg_m),
    .load_m  (load_m),
    .rd_w    (rd_w),
    .wreg_w  (wreg_w),
    .fwd_sel (fwd_b_raw)
  );

  // Forwarding is pure combinational, forced to regfile while in reset
  assign fwd_a = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst_n ? fwd_b_raw : FWD_RF;

  // Hazard priority: error hold, memory wait, branch flush, load-use
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    stall_m  = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    flush_mw = 1'b0;
    if (rst_n) begin
      if (state_q == ST_ERR) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (mem_wait) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        stall_m  = 1'b1;
        flush_mw = 1'b1;
      end else if (br_taken_m) begin
        flush_fd = 1'b1;
        flush_de = 1'b1;
        flush_em = 1'b1;
      end else if (load_use) begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        flush_de = 1'b1;
      end
    end
  end

  // Memory-wait FSM, timeout counter and event counters
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_f);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_fd);
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = TO_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
          state_d    = ST_ERR;
          mem_err_d  = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      ST_ERR: begin
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // State registers; reset brings everything back to RUN with no replay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage pipeline (fetch, decode, execute, datamem, writeback).
- Watches register addresses and control info carried in each stage, and the data-memory ready handshake.
- Drives per-stage stall (hold) and flush (bubble insert) controls, plus forwarding selects for the execute-stage ALU operands.
- Contains the memory-wait FSM, timeout detection, and performance counters.

Parameters:
- CNT_W, 32, width of stall and flush performance counters.
- MEM_TIMEOUT, 255, max consecutive dmem wait cycles before mem_err.
- TO_W, 8, width of the wait-cycle counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1_d  in  5  decode-stage source reg 1 address.
- rs2_d  in  5  decode-stage source reg 2 address.
- use_r2_d  in  1  decode instruction reads rs2.
- rs1_e  in  5  execute-stage source reg 1 address.
- rs2_e  in  5  execute-stage source reg 2 address.
- rd_e  in  5  execute-stage destination address.
- wreg_e  in  1  execute-stage writes register.
- load_e  in  3  execute-stage load info; nonzero means load.
- rd_m  in  5  datamem-stage destination address.
- wreg_m  in  1  datamem-stage writes register.
- load_m  in  3  datamem-stage load info.
- store_m  in  2  datamem-stage store info; nonzero means store.
- br_taken_m  in  1  branch/jump resolved taken, instruction in datamem stage.
- rd_w  in  5  writeback destination address.
- wreg_w  in  1  writeback writes register.
- dmem_ready  in  1  data memory access completes this cycle.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold IF/ID register.
- stall_e  out  1  hold ID/EX register.
- stall_m  out  1  hold EX/MEM register.
- flush_fd  out  1  clear IF/ID register.
- flush_de  out  1  clear ID/EX register.
- flush_em  out  1  clear EX/MEM register.
- flush_mw  out  1  clear MEM/WB register.
- fwd_a  out  2  ALU operand A select: 00 regfile, 01 EX/MEM result, 10 writeback data.
- fwd_b  out  2  ALU operand B select, same encoding.
- mem_err  out  1  sticky dmem timeout flag.
- stall_cnt  out  CNT_W  cycles with stall_f asserted.
- flush_cnt  out  CNT_W  branch flush events.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to RUN.
  - Wait counter, mem_err, stall_cnt and flush_cnt clear to 0.
  - While in reset, all stall/flush outputs are 0 and fwd_a/fwd_b are 00.
  - Deassertion mid-wait resumes in RUN; there is no replay.
- FSM states: RUN, MEM_WAIT, ERR.
  - RUN -> MEM_WAIT when (load_m!=0 or store_m!=0) and dmem_ready=0.
  - MEM_WAIT -> RUN when dmem_ready=1.
  - MEM_WAIT -> ERR when the wait counter reaches MEM_TIMEOUT with dmem_ready still 0.
  - ERR: sets mem_err and holds every stall asserted until reset.
- Memory wait:
  - Applies in any cycle with a memory op in MEM and dmem_ready=0, including the first cycle (Mealy).
  - Asserts stall_f, stall_d, stall_e, stall_m and flush_mw.
  - All other flushes are 0. Highest priority.
- Branch flush:
  - Applies when br_taken_m=1 and no memory wait.
  - Asserts flush_fd, flush_de, flush_em for exactly 1 cycle; no stalls.
  - flush_cnt increments by 1.
- Load-use stall:
  - Condition: wreg_e=1, load_e!=0, rd_e!=0, and (rd_e==rs1_d or (use_r2_d=1 and rd_e==rs2_d)).
  - Applies only with no memory wait and no branch flush; a branch flush squashes the hazard.
  - Asserts stall_f, stall_d, flush_de for 1 cycle.
- Forwarding (per operand, combinational, independent of stalls):
  - EX/MEM match: wreg_m=1, rd_m!=0, load_m==0, rd_m==rs_e -> 01.
  - Else writeback match: wreg_w=1, rd_w!=0, rd_w==rs_e -> 10.
  - Else 00. EX/MEM takes priority over writeback.
- Register x0: never a hazard or forwarding source.
- Counters:
  - stall_cnt increments on every clock with stall_f=1.
  - Both counters wrap modulo 2^CNT_W.
- Wait counter: resets to 0 whenever dmem_ready=1 or the state is RUN without a wait.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state encoding.
  - FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
  - Register address width 5.
  - Load/store/branch info widths (3/2/3).
- Sub-module fwd_unit (pure combinational, instantiated twice, once per operand) computes one forwarding select.
- The FSM, hazard priority logic and counters stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: rd_e=5, wreg_e=1, load_e=3'b010, rs1_d=5 -> stall_f=stall_d=flush_de=1 for one cycle; stall_cnt 0->1.
- Forwarding priority: rd_m=7, wreg_m=1, load_m=0, rd_w=7, wreg_w=1, rs1_e=7, rs2_e=0 -> fwd_a=01, fwd_b=00.
- Branch beats load-use: br_taken_m=1 with the load-use condition also true -> flush_fd=flush_de=flush_em=1, stall_f=0, flush_cnt=1.
- Memory wait: store_m=2'b01, dmem_ready low 3 cycles then high -> stall_f/d/e/m and flush_mw high 3 cycles, then 0; stall_cnt=3.
- Timeout: load_m!=0, dmem_ready=0 for 256 cycles -> mem_err=1, stalls stay high; drop rst_n -> all outputs 0 immediately, without waiting for clk.
- x0 guard: rd_e=0, load_e!=0, rs1_d=0 -> no stall; rd_m=0, rs1_e=0 -> fwd_a=00.
